// File: rtl/seq_table_loader_if.sv
// Host-side bus of the sequencer table loader: load control, word stream,
// sequencer table-port strobes and status.
interface seq_table_loader_if;
    logic        load_start_i;
    logic [15:0] load_length_i;
    logic        abort_i;
    logic        seq_active_i;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic        TABLE_START_o;
    logic [31:0] TABLE_DATA_o;
    logic        TABLE_WSTB_o;
    logic [15:0] TABLE_LENGTH_o;
    logic        TABLE_LENGTH_WSTB_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [15:0] words_loaded_o;

    modport slave (
        input  load_start_i, load_length_i, abort_i, seq_active_i,
               word_i, word_valid_i,
        output word_ready_o, TABLE_START_o, TABLE_DATA_o, TABLE_WSTB_o,
               TABLE_LENGTH_o, TABLE_LENGTH_WSTB_o, busy_o, done_o,
               err_o, err_code_o, words_loaded_o
    );

    modport master (
        output load_start_i, load_length_i, abort_i, seq_active_i,
               word_i, word_valid_i,
        input  word_ready_o, TABLE_START_o, TABLE_DATA_o, TABLE_WSTB_o,
               TABLE_LENGTH_o, TABLE_LENGTH_WSTB_o, busy_o, done_o,
               err_o, err_code_o, words_loaded_o
    );
endinterface

// File: rtl/seq_table_loader.sv
// Sequences a table load into the sequencer: start pulse, one write per
// streamed word, then a length commit. Refuses loads while the sequencer runs.
module seq_table_loader #(
    parameter int MAX_LINES = 1024
) (
    input  logic                clk_i,
    input  logic                reset_i,
    seq_table_loader_if.slave   bus
);
    localparam logic [16:0] MAX_WORDS = 17'(4 * MAX_LINES);

    typedef enum logic [2:0] {IDLE, START, STREAM, COMMIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] count_q, count_d;
    logic [31:0] data_q, data_d;
    logic        wstb_q, wstb_d;
    logic [15:0] tlen_q, tlen_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic word_ready;
    logic bad_len;

    // Ready depends on registered state only, never on valid or abort.
    assign word_ready = (state_q == STREAM) && (count_q < len_q);
    assign bad_len    = (bus.load_length_i == 16'd0)
                     || (bus.load_length_i[1:0] != 2'd0)
                     || ({1'b0, bus.load_length_i} > MAX_WORDS);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        data_d  = data_q;
        wstb_d  = 1'b0;
        tlen_d  = tlen_q;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (bus.load_start_i) begin
                    if (bus.seq_active_i) begin
                        err_d  = 1'b1;
                        code_d = 2'd1;
                    end else if (bad_len) begin
                        err_d  = 1'b1;
                        code_d = 2'd2;
                    end else begin
                        len_d   = bus.load_length_i;
                        count_d = 16'd0;
                        err_d   = 1'b0;
                        code_d  = 2'd0;
                        state_d = START;
                    end
                end
            end
            START: begin
                if (bus.abort_i) begin
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                    state_d = IDLE;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // An abort wins over a word handed over in the same cycle.
                if (bus.abort_i) begin
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                    state_d = IDLE;
                end else if (word_ready && bus.word_valid_i) begin
                    data_d  = bus.word_i;
                    wstb_d  = 1'b1;
                    count_d = count_q + 16'd1;
                    if (count_q + 16'd1 == len_q) begin
                        tlen_d  = len_q;
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            wstb_q  <= 1'b0;
            tlen_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            data_q  <= data_d;
            wstb_q  <= wstb_d;
            tlen_q  <= tlen_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.word_ready_o        = word_ready;
    assign bus.TABLE_START_o       = (state_q == START);
    assign bus.TABLE_DATA_o        = data_q;
    assign bus.TABLE_WSTB_o        = wstb_q;
    assign bus.TABLE_LENGTH_o      = tlen_q;
    assign bus.TABLE_LENGTH_WSTB_o = (state_q == COMMIT);
    assign bus.busy_o              = (state_q != IDLE);
    assign bus.done_o              = (state_q == DONE);
    assign bus.err_o               = err_q;
    assign bus.err_code_o          = code_q;
    assign bus.words_loaded_o      = count_q;
endmodule

// File: tb/tb_seq_table_loader.sv
// Self-checking bench for seq_table_loader: expected table writes and length
// commits are queued when a load is issued and popped as the strobes appear.
module tb_seq_table_loader;
    localparam int MAXL = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_table_loader_if bus();

    seq_table_loader #(.MAX_LINES(MAXL)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];
    logic [15:0] len_q[$];
    int start_cyc[$];
    int wstb_cyc[$];
    int lw_cyc[$];
    int done_cyc[$];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [31:0] e;
        logic [15:0] l;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.TABLE_START_o) start_cyc.push_back(cyc);
                if (bus.done_o) done_cyc.push_back(cyc);
                if (bus.TABLE_WSTB_o) begin
                    wstb_cyc.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL wstb_unexpected: got data %0h at cycle %0d, expected no strobe", bus.TABLE_DATA_o, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.TABLE_DATA_o !== e) begin
                            errors++;
                            $display("FAIL wstb_data: got %0h expected %0h", bus.TABLE_DATA_o, e);
                        end
                    end
                end
                if (bus.TABLE_LENGTH_WSTB_o) begin
                    lw_cyc.push_back(cyc);
                    checks++;
                    if (len_q.size() == 0) begin
                        errors++;
                        $display("FAIL length_unexpected: got length %0d, expected no commit", bus.TABLE_LENGTH_o);
                    end else begin
                        l = len_q.pop_front();
                        if (bus.TABLE_LENGTH_o !== l) begin
                            errors++;
                            $display("FAIL length_commit: got %0d expected %0d", bus.TABLE_LENGTH_o, l);
                        end
                    end
                end
            end
        end
    endtask

    task automatic start_load(input logic [15:0] len);
        bus.load_start_i  = 1'b1;
        bus.load_length_i = len;
        tick();
        bus.load_start_i  = 1'b0;
    endtask

    // Source model: presents words first.., optionally every other cycle;
    // raises abort with word abort_idx, and a stray start with word restart_idx.
    task automatic drive_stream(input int n, input logic [31:0] first, input bit throttle,
                                input int abort_idx, input int restart_idx);
        int sent = 0;
        int t = 0;
        bit acc;
        bit ab;
        while (sent < n && t < 200) begin
            bus.word_valid_i  = !throttle || (t % 2 == 0);
            bus.word_i        = first + 32'(sent);
            acc               = bus.word_valid_i && bus.word_ready_o;
            ab                = acc && (sent == abort_idx);
            bus.abort_i       = ab;
            bus.load_start_i  = acc && (sent == restart_idx);
            bus.load_length_i = 16'd4;
            tick();
            bus.abort_i      = 1'b0;
            bus.load_start_i = 1'b0;
            t++;
            if (ab) break;
            if (acc) sent++;
        end
        bus.word_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_cyc.size() > base) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bus.load_start_i = 0; bus.load_length_i = 0; bus.abort_i = 0;
        bus.seq_active_i = 0; bus.word_i = 0; bus.word_valid_i = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.TABLE_START_o, bus.TABLE_WSTB_o, bus.TABLE_LENGTH_WSTB_o, bus.busy_o,
             bus.done_o, bus.err_o, bus.word_ready_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got start/wstb/lwstb/busy/done/err/ready=%b expected 0000000",
                     {bus.TABLE_START_o, bus.TABLE_WSTB_o, bus.TABLE_LENGTH_WSTB_o, bus.busy_o,
                      bus.done_o, bus.err_o, bus.word_ready_o});
        end
        checks++;
        if (bus.err_code_o !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", bus.err_code_o); end
        checks++;
        if (bus.TABLE_LENGTH_o !== 16'd0) begin errors++; $display("FAIL reset_length: got %0d expected 0", bus.TABLE_LENGTH_o); end
        checks++;
        if (bus.words_loaded_o !== 16'd0 || bus.TABLE_DATA_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts: got words=%0d data=%0h expected 0/0", bus.words_loaded_o, bus.TABLE_DATA_o);
        end
    endtask

    task automatic test_normal();
        int n, bs, bw, bl, bd;
        bit ok;
        bs = start_cyc.size(); bw = wstb_cyc.size(); bl = lw_cyc.size(); bd = done_cyc.size();
        for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
        len_q.push_back(16'd8);
        n = cyc;
        start_load(16'd8);
        checks++;
        if (bus.TABLE_START_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.word_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL normal_start: got start=%b busy=%b ready=%b expected 1 1 0",
                     bus.TABLE_START_o, bus.busy_o, bus.word_ready_o);
        end
        drive_stream(8, 32'd1, 1'b0, -1, -1);
        wait_done(bd, ok);
        checks++;
        if (!ok || done_cyc[bd] != n + 11) begin
            errors++;
            $display("FAIL normal_done_time: got done_seen=%b cycle offset %0d expected 11", ok, ok ? done_cyc[bd] - n : -1);
        end
        checks++;
        if (start_cyc.size() - bs != 1 || start_cyc[bs] != n + 1) begin
            errors++;
            $display("FAIL normal_start_count: got %0d pulses expected 1 at offset 1", start_cyc.size() - bs);
        end
        checks++;
        if (wstb_cyc.size() - bw != 8 || wstb_cyc[bw] != n + 3 || wstb_cyc[bw + 7] != n + 10) begin
            errors++;
            $display("FAIL normal_wstb_timing: got %0d strobes first=%0d last=%0d expected 8 at offsets 3..10",
                     wstb_cyc.size() - bw, wstb_cyc[bw] - n, wstb_cyc[bw + 7] - n);
        end
        checks++;
        if (lw_cyc.size() - bl != 1 || lw_cyc[bl] != n + 10) begin
            errors++;
            $display("FAIL normal_commit_time: got %0d commits, offset %0d, expected 1 at offset 10", lw_cyc.size() - bl, lw_cyc[bl] - n);
        end
        checks++;
        if (bus.words_loaded_o !== 16'd8 || bus.TABLE_LENGTH_o !== 16'd8) begin
            errors++;
            $display("FAIL normal_counts: got words=%0d length=%0d expected 8/8", bus.words_loaded_o, bus.TABLE_LENGTH_o);
        end
        tick();
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL normal_busy_low: got %b expected 0", bus.busy_o); end
        repeat (3) tick();
        checks++;
        if (done_cyc.size() - bd != 1) begin errors++; $display("FAIL normal_done_once: got %0d expected 1", done_cyc.size() - bd); end
    endtask

    task automatic test_throttled();
        int bw, bl, bd;
        bit ok;
        bw = wstb_cyc.size(); bl = lw_cyc.size(); bd = done_cyc.size();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd101 + 32'(i));
        len_q.push_back(16'd4);
        start_load(16'd4);
        drive_stream(4, 32'd101, 1'b1, -1, -1);
        wait_done(bd, ok);
        checks++;
        if (!ok || wstb_cyc.size() - bw != 4) begin
            errors++;
            $display("FAIL throttle_count: got done=%b strobes=%0d expected 1/4", ok, wstb_cyc.size() - bw);
        end
        checks++;
        if (wstb_cyc[bw + 1] - wstb_cyc[bw] != 2 || wstb_cyc[bw + 3] - wstb_cyc[bw + 2] != 2) begin
            errors++;
            $display("FAIL throttle_spacing: got gaps %0d,%0d expected 2,2",
                     wstb_cyc[bw + 1] - wstb_cyc[bw], wstb_cyc[bw + 3] - wstb_cyc[bw + 2]);
        end
        checks++;
        if (lw_cyc.size() - bl != 1 || lw_cyc[bl] != wstb_cyc[bw + 3]) begin
            errors++;
            $display("FAIL throttle_commit: got %0d commits at %0d expected 1 at %0d", lw_cyc.size() - bl, lw_cyc[bl], wstb_cyc[bw + 3]);
        end
        tick();
    endtask

    task automatic test_rejections();
        int bs, bd;
        bit ok;
        bs = start_cyc.size();
        bus.seq_active_i = 1'b1;
        start_load(16'd8);
        bus.seq_active_i = 1'b0;
        checks++;
        if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'd1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reject_seq_busy: got err=%b code=%0d busy=%b expected 1 1 0", bus.err_o, bus.err_code_o, bus.busy_o);
        end
        tick();
        checks++;
        if (start_cyc.size() != bs) begin errors++; $display("FAIL reject_no_start: got %0d pulses expected 0", start_cyc.size() - bs); end
        start_load(16'd6);
        tick(); tick();
        checks++;
        if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'd2) begin
            errors++;
            $display("FAIL reject_len6: got err=%b code=%0d expected 1 2", bus.err_o, bus.err_code_o);
        end
        start_load(16'(4 * MAXL + 4));
        checks++;
        if (bus.err_code_o !== 2'd2 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reject_too_long: got code=%0d busy=%b expected 2 0", bus.err_code_o, bus.busy_o);
        end
        start_load(16'd0);
        checks++;
        if (bus.err_code_o !== 2'd2 || start_cyc.size() != bs) begin
            errors++;
            $display("FAIL reject_zero: got code=%0d starts=%0d expected 2 0", bus.err_code_o, start_cyc.size() - bs);
        end
        bd = done_cyc.size();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd201 + 32'(i));
        len_q.push_back(16'd4);
        start_load(16'd4);
        checks++;
        if (bus.err_o !== 1'b0 || bus.err_code_o !== 2'd0 || bus.TABLE_START_o !== 1'b1) begin
            errors++;
            $display("FAIL reject_clear: got err=%b code=%0d start=%b expected 0 0 1", bus.err_o, bus.err_code_o, bus.TABLE_START_o);
        end
        drive_stream(4, 32'd201, 1'b0, -1, -1);
        wait_done(bd, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reject_followup_done: got no done expected done"); end
        tick();
    endtask

    task automatic test_max_length();
        start_load(16'(4 * MAXL));
        checks++;
        if (bus.TABLE_START_o !== 1'b1 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL maxlen_accept: got start=%b err=%b expected 1 0", bus.TABLE_START_o, bus.err_o);
        end
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.err_code_o !== 2'd3) begin
            errors++;
            $display("FAIL maxlen_abort_start: got busy=%b code=%0d expected 0 3", bus.busy_o, bus.err_code_o);
        end
        tick();
    endtask

    task automatic test_abort();
        int bw, bl;
        bw = wstb_cyc.size(); bl = lw_cyc.size();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd301 + 32'(i));
        start_load(16'd16);
        drive_stream(16, 32'd301, 1'b0, 4, -1);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b1 || bus.err_code_o !== 2'd3) begin
            errors++;
            $display("FAIL abort_state: got busy=%b err=%b code=%0d expected 0 1 3", bus.busy_o, bus.err_o, bus.err_code_o);
        end
        repeat (3) tick();
        checks++;
        if (wstb_cyc.size() - bw != 4 || lw_cyc.size() != bl) begin
            errors++;
            $display("FAIL abort_strobes: got %0d writes %0d commits expected 4 0", wstb_cyc.size() - bw, lw_cyc.size() - bl);
        end
        checks++;
        if (bus.TABLE_LENGTH_o !== 16'd4 || bus.words_loaded_o !== 16'd4) begin
            errors++;
            $display("FAIL abort_hold: got length=%0d words=%0d expected 4 4", bus.TABLE_LENGTH_o, bus.words_loaded_o);
        end
    endtask

    task automatic test_reset_mid_stream();
        int bd;
        bit ok;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'd401 + 32'(i));
        start_load(16'd16);
        drive_stream(3, 32'd401, 1'b0, -1, -1);
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.TABLE_START_o, bus.TABLE_WSTB_o, bus.TABLE_LENGTH_WSTB_o, bus.busy_o,
             bus.done_o, bus.err_o, bus.word_ready_o} !== 7'b0 || bus.err_code_o !== 2'd0) begin
            errors++;
            $display("FAIL midreset_flags: got flags=%b code=%0d expected 0 0",
                     {bus.TABLE_START_o, bus.TABLE_WSTB_o, bus.TABLE_LENGTH_WSTB_o, bus.busy_o,
                      bus.done_o, bus.err_o, bus.word_ready_o}, bus.err_code_o);
        end
        checks++;
        if (bus.TABLE_LENGTH_o !== 16'd0 || bus.words_loaded_o !== 16'd0 || bus.TABLE_DATA_o !== 32'd0) begin
            errors++;
            $display("FAIL midreset_values: got length=%0d words=%0d data=%0h expected 0 0 0",
                     bus.TABLE_LENGTH_o, bus.words_loaded_o, bus.TABLE_DATA_o);
        end
        rst = 1'b0;
        tick();
        bd = done_cyc.size();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd411 + 32'(i));
        len_q.push_back(16'd4);
        start_load(16'd4);
        drive_stream(4, 32'd411, 1'b0, -1, -1);
        wait_done(bd, ok);
        checks++;
        if (!ok || bus.TABLE_LENGTH_o !== 16'd4) begin
            errors++;
            $display("FAIL midreset_reload: got done=%b length=%0d expected 1 4", ok, bus.TABLE_LENGTH_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int bs, bd, n;
        bit ok;
        bs = start_cyc.size(); bd = done_cyc.size();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'd501 + 32'(i));
        len_q.push_back(16'd8);
        start_load(16'd8);
        drive_stream(8, 32'd501, 1'b0, -1, 3);
        checks++;
        if (bus.err_o !== 1'b0 || bus.err_code_o !== 2'd0) begin
            errors++;
            $display("FAIL b2b_ignored_start_err: got err=%b code=%0d expected 0 0", bus.err_o, bus.err_code_o);
        end
        wait_done(bd, ok);
        checks++;
        if (!ok || start_cyc.size() - bs != 1 || bus.TABLE_LENGTH_o !== 16'd8) begin
            errors++;
            $display("FAIL b2b_first_load: got done=%b starts=%0d length=%0d expected 1 1 8",
                     ok, start_cyc.size() - bs, bus.TABLE_LENGTH_o);
        end
        tick();
        bd = done_cyc.size();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd511 + 32'(i));
        len_q.push_back(16'd4);
        n = cyc;
        start_load(16'd4);
        checks++;
        if (bus.TABLE_START_o !== 1'b1 || start_cyc.size() - bs != 2 || start_cyc[bs + 1] != n + 1) begin
            errors++;
            $display("FAIL b2b_restart: got start=%b pulses=%0d expected 1 2", bus.TABLE_START_o, start_cyc.size() - bs);
        end
        drive_stream(4, 32'd511, 1'b0, -1, -1);
        wait_done(bd, ok);
        checks++;
        if (!ok || bus.TABLE_LENGTH_o !== 16'd4) begin
            errors++;
            $display("FAIL b2b_second_load: got done=%b length=%0d expected 1 4", ok, bus.TABLE_LENGTH_o);
        end
        repeat (3) tick();
    endtask

    task automatic test_drain();
        checks++;
        if (exp_q.size() != 0 || len_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d writes %0d commits outstanding expected 0 0", exp_q.size(), len_q.size());
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_normal();
        test_throttled();
        test_rejections();
        test_max_length();
        test_abort();
        test_reset_mid_stream();
        test_back_to_back();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
